alu_issue_stage: RTL and testbench

ID/EX pipeline register that sits directly upstream of the 32-bit ALU.
- Captures decoded instruction fields from the decode stage.
- Resolves operand forwarding from EX/MEM and MEM/WB.
- Translates ALUOp/funct into the ALU's 4-bit op code.
- Presents registered A, B and op to the ALU behind a valid/ready handshake, with stall and flush support.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_issue_stage_if.sv | 47 ++++
 rtl/alu_ctrl_dec.sv | 37 +++
 rtl/alu_issue_stage.sv | 115 +++++++++++
 tb/tb_alu_issue_stage.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: ALU op codes, ALUOp encodings
// and R-type funct values.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_ADDI  = 2'b11
  } aluop_e;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side, forwarding and ALU-side signals of the issue stage.
// master = surrounding pipeline, slave = the issue stage itself.
interface alu_issue_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [15:0]   imm;
  logic          alu_src;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic [RW-1:0] rs_addr;
  logic [RW-1:0] rt_addr;
  logic [RW-1:0] rd_addr;
  logic          exm_we;
  logic [RW-1:0] exm_rd;
  logic [DW-1:0] exm_res;
  logic          mwb_we;
  logic [RW-1:0] mwb_rd;
  logic [DW-1:0] mwb_res;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_opc;
  logic [RW-1:0] out_rd;
  logic [DW-1:0] out_rt;
  logic          illegal;

  modport master (
    output in_valid, flush, rs_data, rt_data, imm, alu_src, alu_op, funct,
           rs_addr, rt_addr, rd_addr, exm_we, exm_rd, exm_res,
           mwb_we, mwb_rd, mwb_res, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_opc, out_rd, out_rt, illegal
  );

  modport slave (
    input  in_valid, flush, rs_data, rt_data, imm, alu_src, alu_op, funct,
           rs_addr, rt_addr, rd_addr, exm_we, exm_rd, exm_res,
           mwb_we, mwb_rd, mwb_res, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_opc, out_rd, out_rt, illegal
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// ALU control decoder: maps (ALUOp, funct) to the ALU's 4-bit op code and
// flags R-type funct values the ALU does not implement.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] opc_o,
  output logic       illegal_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    opc_o     = ALU_ADD;
    illegal_o = 1'b0;
    case (aluop_e'(alu_op_i))
      ALUOP_ADD, ALUOP_ADDI: opc_o = ALU_ADD;
      ALUOP_SUB:             opc_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  opc_o = ALU_ADD;
          FN_SUB:  opc_o = ALU_SUB;
          FN_AND:  opc_o = ALU_AND;
          FN_OR:   opc_o = ALU_OR;
          FN_SLT:  opc_o = ALU_SLT;
          FN_NOR:  opc_o = ALU_NOR;
          default: begin
            opc_o     = ALU_BAD;
            illegal_o = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX register feeding the 32-bit ALU: operand forwarding, ALU control
// decode and a single-entry valid/ready stage. Forwarding is built only when
// ALU_ISSUE_FWD_EN is defined; otherwise register-file data is used directly.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic            clk,
  input logic            rst,
  alu_issue_stage_if.slave bus
);

  logic          valid_q, valid_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] rt_q, rt_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [3:0]    opc_q, opc_d;
  logic          ill_q, ill_d;

  logic          load;
  logic [DW-1:0] rs_fwd, rt_fwd, imm_ext;
  logic [3:0]    dec_opc;
  logic          dec_ill;

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready && !bus.flush;
  assign imm_ext      = {{(DW-16){bus.imm[15]}}, bus.imm};

`ifdef ALU_ISSUE_FWD_EN
  // The younger EX/MEM result shadows MEM/WB; r0 is hard-wired and never forwarded.
  always_comb begin
    rs_fwd = bus.rs_data;
    rt_fwd = bus.rt_data;
    if (bus.rs_addr != '0) begin
      if (bus.exm_we && bus.exm_rd == bus.rs_addr)      rs_fwd = bus.exm_res;
      else if (bus.mwb_we && bus.mwb_rd == bus.rs_addr) rs_fwd = bus.mwb_res;
    end
    if (bus.rt_addr != '0) begin
      if (bus.exm_we && bus.exm_rd == bus.rt_addr)      rt_fwd = bus.exm_res;
      else if (bus.mwb_we && bus.mwb_rd == bus.rt_addr) rt_fwd = bus.mwb_res;
    end
  end
`else
  logic unused_fwd;
  assign rs_fwd     = bus.rs_data;
  assign rt_fwd     = bus.rt_data;
  assign unused_fwd = ^{bus.rs_addr, bus.rt_addr, bus.exm_we, bus.exm_rd, bus.exm_res,
                        bus.mwb_we, bus.mwb_rd, bus.mwb_res};
`endif

  alu_ctrl_dec u_dec (
    .alu_op_i  (bus.alu_op),
    .funct_i   (bus.funct),
    .opc_o     (dec_opc),
    .illegal_o (dec_ill)
  );

  // Flush outranks load; data registers keep their contents when the entry drains.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    opc_d   = opc_q;
    ill_d   = ill_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      a_d     = rs_fwd;
      b_d     = bus.alu_src ? imm_ext : rt_fwd;
      rt_d    = rt_fwd;
      rd_d    = bus.rd_addr;
      opc_d   = dec_opc;
      ill_d   = dec_ill;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      opc_q   <= ALU_AND;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      opc_q   <= opc_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.out_rt    = rt_q;
  assign bus.out_rd    = rd_q;
  assign bus.alu_opc   = opc_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic chk_en = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rt;
    logic [4:0]  rd;
    logic [3:0]  opc;
    logic        ill;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] fn_map[logic [5:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_fwd(input logic [4:0] addr, input logic [31:0] rf);
    if (FWD_ON && addr != 5'd0) begin
      if (bus.exm_we && bus.exm_rd == addr) return bus.exm_res;
      if (bus.mwb_we && bus.mwb_rd == addr) return bus.mwb_res;
    end
    return rf;
  endfunction

  // Reference model: a one-deep queue of what the ALU should see next.
  exp_t m_e;
  bit   m_space;
  always @(posedge clk) begin
    if (rst || bus.flush) begin
      exp_q.delete();
    end else begin
      m_space = (exp_q.size() == 0) || bus.out_ready;
      if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
      if (bus.in_valid && m_space) begin
        m_e.a   = model_fwd(bus.rs_addr, bus.rs_data);
        m_e.rt  = model_fwd(bus.rt_addr, bus.rt_data);
        m_e.b   = bus.alu_src ? {{16{bus.imm[15]}}, bus.imm} : m_e.rt;
        m_e.rd  = bus.rd_addr;
        m_e.ill = 1'b0;
        if (bus.alu_op == 2'b01)      m_e.opc = 4'b0110;
        else if (bus.alu_op != 2'b10) m_e.opc = 4'b0010;
        else if (fn_map.exists(bus.funct)) m_e.opc = fn_map[bus.funct];
        else begin
          m_e.opc = 4'b1111;
          m_e.ill = 1'b1;
        end
        exp_q.push_back(m_e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
      check("m_in_ready", {31'd0, bus.in_ready}, {31'd0, (exp_q.size() == 0) || bus.out_ready});
      if (exp_q.size() != 0) begin
        check("m_alu_a", bus.alu_a, exp_q[0].a);
        check("m_alu_b", bus.alu_b, exp_q[0].b);
        check("m_out_rt", bus.out_rt, exp_q[0].rt);
        check("m_out_rd", {27'd0, bus.out_rd}, {27'd0, exp_q[0].rd});
        check("m_alu_opc", {28'd0, bus.alu_opc}, {28'd0, exp_q[0].opc});
        check("m_illegal", {31'd0, bus.illegal}, {31'd0, exp_q[0].ill});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.rs_data   = '0;
    bus.rt_data   = '0;
    bus.imm       = '0;
    bus.alu_src   = 1'b0;
    bus.alu_op    = 2'b00;
    bus.funct     = '0;
    bus.rs_addr   = '0;
    bus.rt_addr   = '0;
    bus.rd_addr   = '0;
    bus.exm_we    = 1'b0;
    bus.exm_rd    = '0;
    bus.exm_res   = '0;
    bus.mwb_we    = 1'b0;
    bus.mwb_rd    = '0;
    bus.mwb_res   = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] im, input logic src,
                       input logic [4:0] ra, input logic [4:0] ta, input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
    bus.imm      = im;
    bus.alu_src  = src;
    bus.rs_addr  = ra;
    bus.rt_addr  = ta;
    bus.rd_addr  = rd;
  endtask

  initial begin
    logic [5:0] fns[6];
    logic [3:0] opcs[6];
    fn_map[6'b100000] = 4'b0010;
    fn_map[6'b100010] = 4'b0110;
    fn_map[6'b100100] = 4'b0000;
    fn_map[6'b100101] = 4'b0001;
    fn_map[6'b101010] = 4'b0111;
    fn_map[6'b100111] = 4'b1100;
    fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    opcs = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

    rst = 1'b1;
    idle_inputs();
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_alu_opc", {28'd0, bus.alu_opc}, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // R-type slt, then lw with negative immediate
    bus.out_ready = 1'b1;
    issue(2'b10, 6'b101010, 32'd5, 32'd9, 16'h0000, 1'b0, 5'd1, 5'd2, 5'd7);
    cyc();
    check("slt_valid", {31'd0, bus.out_valid}, 32'd1);
    check("slt_opc", {28'd0, bus.alu_opc}, 32'h7);
    check("slt_a", bus.alu_a, 32'd5);
    check("slt_b", bus.alu_b, 32'd9);
    check("slt_rd", {27'd0, bus.out_rd}, 32'd7);
    issue(2'b00, 6'b111111, 32'd100, 32'd3, 16'hFFFC, 1'b1, 5'd4, 5'd5, 5'd6);
    cyc();
    check("lw_b", bus.alu_b, 32'hFFFF_FFFC);
    check("lw_opc", {28'd0, bus.alu_opc}, 32'h2);
    check("lw_a", bus.alu_a, 32'd100);
    check("lw_ill", {31'd0, bus.illegal}, 32'd0);

    // Stall: held lw must stay put while a sub waits upstream
    bus.out_ready = 1'b0;
    issue(2'b01, 6'b000000, 32'd20, 32'd7, 16'h0000, 1'b0, 5'd8, 5'd9, 5'd10);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_b", bus.alu_b, 32'hFFFF_FFFC);
      check("stall_a", bus.alu_a, 32'd100);
    end
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    check("post_stall_opc", {28'd0, bus.alu_opc}, 32'h6);
    check("post_stall_a", bus.alu_a, 32'd20);
    cyc();
    check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // Full funct table
    for (int i = 0; i < 6; i++) begin
      issue(2'b10, fns[i], 32'(i), 32'(i + 40), 16'h0, 1'b0, 5'd1, 5'd2, 5'(i));
      cyc();
      check("funct_opc", {28'd0, bus.alu_opc}, {28'd0, opcs[i]});
    end

    // Forwarding priority
    issue(2'b00, 6'd0, 32'h1111, 32'd2, 16'h0, 1'b0, 5'd3, 5'd0, 5'd1);
    bus.exm_we = 1'b1; bus.exm_rd = 5'd3; bus.exm_res = 32'hAAAA;
    bus.mwb_we = 1'b1; bus.mwb_rd = 5'd3; bus.mwb_res = 32'hBBBB;
    cyc();
    check("fwd_exm_wins", bus.alu_a, FWD_ON ? 32'hAAAA : 32'h1111);
    bus.exm_we = 1'b0;
    cyc();
    check("fwd_mwb", bus.alu_a, FWD_ON ? 32'hBBBB : 32'h1111);
    issue(2'b11, 6'd0, 32'h2222, 32'h3333, 16'h0010, 1'b1, 5'd0, 5'd4, 5'd1);
    bus.exm_we = 1'b1; bus.exm_rd = 5'd0; bus.exm_res = 32'hDEAD;
    bus.mwb_rd = 5'd4;
    cyc();
    check("fwd_r0_blocked", bus.alu_a, 32'h2222);
    check("fwd_rt_store", bus.out_rt, FWD_ON ? 32'hBBBB : 32'h3333);
    check("fwd_imm_b", bus.alu_b, 32'h10);
    bus.exm_we = 1'b0; bus.mwb_we = 1'b0;

    // Flush against load, and flush of a stalled entry
    bus.flush = 1'b1;
    cyc();
    check("flush_load_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    cyc();
    check("pre_flush_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0;
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    check("flush_stall_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_stall_ready", {31'd0, bus.in_ready}, 32'd1);

    // Illegal funct, then flush clears the flag
    bus.out_ready = 1'b1;
    issue(2'b10, 6'b111111, 32'd1, 32'd1, 16'h0, 1'b0, 5'd1, 5'd2, 5'd3);
    cyc();
    check("ill_opc", {28'd0, bus.alu_opc}, 32'hF);
    check("ill_flag", {31'd0, bus.illegal}, 32'd1);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    check("ill_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ill_flush_flag", {31'd0, bus.illegal}, 32'd0);

    // Reset while stalled
    bus.out_ready = 1'b0;
    issue(2'b10, 6'b100111, 32'h55, 32'h66, 16'h0, 1'b0, 5'd1, 5'd2, 5'd9);
    cyc();
    bus.in_valid = 1'b0;
    check("prerst_valid", {31'd0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mrst_opc", {28'd0, bus.alu_opc}, 32'd0);
    check("mrst_a", bus.alu_a, 32'd0);
    check("mrst_b", bus.alu_b, 32'd0);
    check("mrst_rt", bus.out_rt, 32'd0);
    check("mrst_rd", {27'd0, bus.out_rd}, 32'd0);
    check("mrst_ill", {31'd0, bus.illegal}, 32'd0);
    check("mrst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    cyc();
    cyc();
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
